// File: rtl/debounce_bank.sv
// debounce_bank: N-channel button/switch debouncer sharing one millisecond prescaler.
// Each channel: synchroniser, lockout counter, rise/fall pulses and hold-to-repeat pulses.
module debounce_bank #(
  parameter int N               = 4,
  parameter int CLK_KHZ         = 98000,
  parameter int COOLDOWN_MS     = 50,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rep,
  output logic         tick
);

  localparam int PW   = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam int CW   = (COOLDOWN_MS > 0) ? $clog2(COOLDOWN_MS + 1) : 1;
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_KHZ - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);
  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_MS);
  localparam logic [CW-1:0] CD_ONE   = CW'(1);
  localparam logic [CW-1:0] CD_ZERO  = CW'(0);
  localparam logic [RW-1:0] RC_DELAY = RW'(REPEAT_DELAY_MS);
  localparam logic [RW-1:0] RC_RATE  = RW'(REPEAT_RATE_MS);
  localparam logic [RW-1:0] RC_ONE   = RW'(1);
  localparam logic [RW-1:0] RC_ZERO  = RW'(0);

  if (N < 1) begin : g_bad_n
    $error("debounce_bank: N must be >= 1");
  end
  if (CLK_KHZ < 1) begin : g_bad_clk
    $error("debounce_bank: CLK_KHZ must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_bank: SYNC_STAGES must be >= 2");
  end

  logic [PW-1:0] pre_cnt_r;

  // Free-running ms prescaler; tick is high the cycle after the count reaches its top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= PRE_ZERO;
      tick      <= 1'b0;
    end else begin
      pre_cnt_r <= (pre_cnt_r == PRE_LAST) ? PRE_ZERO : pre_cnt_r + PRE_ONE;
      tick      <= (pre_cnt_r == PRE_LAST);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cd_r, cd_nx_s;
    logic [RW-1:0]          rc_r, rc_nx_s;
    logic                   out_r, out_nx_s, rise_r, fall_r, rep_r, rep_nx_s;
    logic                   sync_s, idle_s, change_s;

    assign sync_s   = sync_r[SYNC_STAGES-1];
    assign idle_s   = (cd_r == CD_ZERO);
    assign change_s = idle_s && (sync_s != out_r);

    // Level is only accepted while no lockout runs; lockout counts down on ticks
    always_comb begin
      out_nx_s = out_r;
      cd_nx_s  = cd_r;
      if (idle_s) begin
        out_nx_s = sync_s;
        if (change_s) cd_nx_s = CD_LOAD;
        else          cd_nx_s = cd_r;
      end else if (tick) begin
        cd_nx_s = cd_r - CD_ONE;
      end else begin
        cd_nx_s = cd_r;
      end
    end

    // Repeat: load on the accepted rise (tick ignored there), clear while released
    always_comb begin
      rc_nx_s  = rc_r;
      rep_nx_s = 1'b0;
      if (change_s && sync_s) begin
        rc_nx_s = RC_DELAY;
      end else if (!out_r) begin
        rc_nx_s = RC_ZERO;
      end else if (tick && (rc_r == RC_ONE)) begin
        rep_nx_s = 1'b1;
        rc_nx_s  = RC_RATE;
      end else if (tick && (rc_r > RC_ONE)) begin
        rc_nx_s = rc_r - RC_ONE;
      end else begin
        rc_nx_s = rc_r;
      end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{1'b0}};
        out_r  <= 1'b0;
        cd_r   <= CD_ZERO;
        rc_r   <= RC_ZERO;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        rep_r  <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], in[i]};
        out_r  <= out_nx_s;
        cd_r   <= cd_nx_s;
        rc_r   <= rc_nx_s;
        rise_r <= change_s && sync_s;
        fall_r <= change_s && !sync_s;
        rep_r  <= rep_nx_s;
      end
    end

    assign out[i]  = out_r;
    assign rise[i] = rise_r;
    assign fall[i] = fall_r;
    assign rep[i]  = rep_r;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (N=4, CLK_KHZ=4, COOLDOWN_MS=3, REPEAT 5/2).
// Expected output values are queued with their edge number and compared when that edge is sampled.
module tb_debounce_bank;

  localparam int SIG_OUT  = 0;
  localparam int SIG_RISE = 1;
  localparam int SIG_FALL = 2;
  localparam int SIG_REP  = 3;
  localparam int SIG_TICK = 4;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic [3:0] out, rise, fall, rep;
  logic       tick;

  exp_t sb[$];
  int   ecyc   = 0;
  int   errs   = 0;
  int   total  = 0;
  int   rise_cnt [4] = '{default: 0};
  int   fall_cnt [4] = '{default: 0};
  int   rep_cnt  [4] = '{default: 0};

  debounce_bank #(
    .N(4), .CLK_KHZ(4), .COOLDOWN_MS(3), .SYNC_STAGES(2),
    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .out(out),
    .rise(rise), .fall(fall), .rep(rep), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, act, exp, ecyc);
    end
  endtask

  task automatic expect_at(int cyc, int sig, logic [3:0] val, string tag);
    exp_t e;
    e.cyc = cyc;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] sample(int sig);
    case (sig)
      SIG_OUT:  return out;
      SIG_RISE: return rise;
      SIG_FALL: return fall;
      SIG_REP:  return rep;
      default:  return {3'b000, tick};
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      rise_cnt[c] += int'(rise[c]);
      fall_cnt[c] += int'(fall[c]);
      rep_cnt[c]  += int'(rep[c]);
    end
    while (sb.size() > 0 && sb[0].cyc <= ecyc) begin
      e = sb.pop_front();
      if (e.cyc == ecyc) check(e.tag, 32'(sample(e.sig)), 32'(e.val));
      else               check({e.tag, "_not_reached"}, ecyc, e.cyc);
    end
  endtask

  // one clock: count the edge, then sample on the falling edge
  task automatic cycle();
    @(posedge clk);
    if (!rst) ecyc++;
    @(negedge clk);
    if (!rst) monitor();
  endtask

  task automatic run_to(int e);
    while (ecyc < e) cycle();
  endtask

  initial begin
    // 1. reset with all inputs high
    din = 4'hF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out",  out,  4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_rep",  rep,  4'h0);
    check("rst_tick", tick, 1'b0);
    expect_at(1,  SIG_TICK, 4'h0, "s1_tick1");
    expect_at(2,  SIG_TICK, 4'h0, "s1_tick2");
    expect_at(2,  SIG_OUT,  4'h0, "s1_out2");
    expect_at(3,  SIG_TICK, 4'h0, "s1_tick3");
    expect_at(3,  SIG_OUT,  4'hF, "s1_out3");
    expect_at(3,  SIG_RISE, 4'hF, "s1_rise3");
    expect_at(4,  SIG_TICK, 4'h1, "s1_tick4");
    expect_at(4,  SIG_RISE, 4'h0, "s1_rise4");
    expect_at(5,  SIG_TICK, 4'h0, "s1_tick5");
    expect_at(13, SIG_OUT,  4'hF, "s1_lock_out13");
    expect_at(13, SIG_FALL, 4'h0, "s1_lock_fall13");
    expect_at(14, SIG_OUT,  4'h0, "s1_out14");
    expect_at(14, SIG_FALL, 4'hF, "s1_fall14");
    expect_at(15, SIG_FALL, 4'h0, "s1_fall15");
    rst = 1'b0;
    run_to(3);
    din = 4'h0;
    run_to(29);
    for (int c = 0; c < 4; c++) check($sformatf("s1_rise_once_ch%0d", c), rise_cnt[c], 1);

    // 2. clean press on channel 0
    run_to(30);
    expect_at(32, SIG_OUT,  4'h0, "s2_out32");
    expect_at(32, SIG_RISE, 4'h0, "s2_rise32");
    expect_at(33, SIG_OUT,  4'h1, "s2_out33");
    expect_at(33, SIG_RISE, 4'h1, "s2_rise33");
    expect_at(34, SIG_OUT,  4'h1, "s2_out34");
    expect_at(34, SIG_RISE, 4'h0, "s2_rise34");
    expect_at(45, SIG_OUT,  4'h1, "s2_lock_out45");
    expect_at(46, SIG_OUT,  4'h0, "s2_out46");
    expect_at(46, SIG_FALL, 4'h1, "s2_fall46");
    expect_at(47, SIG_FALL, 4'h0, "s2_fall47");
    din[0] = 1'b1;
    run_to(34);
    din[0] = 1'b0;

    // 3. bouncing channel 1
    run_to(50);
    expect_at(52, SIG_OUT,  4'h0, "s3_out52");
    expect_at(53, SIG_OUT,  4'h2, "s3_out53");
    expect_at(53, SIG_RISE, 4'h2, "s3_rise53");
    expect_at(54, SIG_RISE, 4'h0, "s3_rise54");
    expect_at(65, SIG_OUT,  4'h2, "s3_out65");
    expect_at(66, SIG_OUT,  4'h2, "s3_out66");
    expect_at(66, SIG_FALL, 4'h0, "s3_nofall66");
    expect_at(69, SIG_OUT,  4'h0, "s3_out69");
    expect_at(69, SIG_FALL, 4'h2, "s3_fall69");
    expect_at(70, SIG_FALL, 4'h0, "s3_fall70");
    din[1] = 1'b1;
    for (int t = 52; t <= 58; t += 2) begin
      run_to(t);
      din[1] = ~din[1];
    end
    run_to(66);
    din[1] = 1'b0;

    // 4. single-cycle glitch on channel 2
    run_to(80);
    expect_at(82, SIG_OUT,  4'h0, "s4_out82");
    expect_at(83, SIG_OUT,  4'h4, "s4_out83");
    expect_at(83, SIG_RISE, 4'h4, "s4_rise83");
    expect_at(84, SIG_RISE, 4'h0, "s4_rise84");
    expect_at(93, SIG_OUT,  4'h4, "s4_held93");
    expect_at(94, SIG_OUT,  4'h0, "s4_out94");
    expect_at(94, SIG_FALL, 4'h4, "s4_fall94");
    expect_at(95, SIG_FALL, 4'h0, "s4_fall95");
    din[2] = 1'b1;
    run_to(81);
    din[2] = 1'b0;

    // 5. hold channel 3 for 60 cycles: rep at 5th tick after rise, then every 2nd tick
    run_to(108);
    expect_at(110, SIG_OUT,  4'h0, "s5_out110");
    expect_at(111, SIG_OUT,  4'h8, "s5_out111");
    expect_at(111, SIG_RISE, 4'h8, "s5_rise111");
    expect_at(112, SIG_RISE, 4'h0, "s5_rise112");
    expect_at(128, SIG_REP,  4'h0, "s5_rep128");
    for (int f = 129; f <= 169; f += 8) begin
      expect_at(f,     SIG_REP, 4'h8, $sformatf("s5_rep%0d", f));
      expect_at(f + 1, SIG_REP, 4'h0, $sformatf("s5_rep%0d", f + 1));
    end
    expect_at(170, SIG_OUT,  4'h8, "s5_out170");
    expect_at(171, SIG_OUT,  4'h0, "s5_out171");
    expect_at(171, SIG_FALL, 4'h8, "s5_fall171");
    expect_at(171, SIG_REP,  4'h0, "s5_rep171");
    expect_at(172, SIG_FALL, 4'h0, "s5_fall172");
    din[3] = 1'b1;
    run_to(168);
    din[3] = 1'b0;
    run_to(189);
    check("s5_rep_count", rep_cnt[3], 6);

    // 6. asynchronous reset during channel 0 lockout
    run_to(190);
    expect_at(192, SIG_OUT,  4'h0, "s6_out192");
    expect_at(193, SIG_OUT,  4'h1, "s6_out193");
    expect_at(193, SIG_RISE, 4'h1, "s6_rise193");
    din[0] = 1'b1;
    run_to(194);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_out",  out,  4'h0);
    check("s6_async_rise", rise, 4'h0);
    check("s6_async_rep",  rep,  4'h0);
    check("s6_async_tick", tick, 1'b0);
    ecyc = 0;
    din  = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("s6_rst_hold_out", out, 4'h0);
    expect_at(1,  SIG_TICK, 4'h0, "s6_tick1");
    expect_at(3,  SIG_TICK, 4'h0, "s6_tick3");
    expect_at(4,  SIG_TICK, 4'h1, "s6_tick4");
    expect_at(4,  SIG_OUT,  4'h0, "s6_out4");
    expect_at(5,  SIG_OUT,  4'h1, "s6_out5");
    expect_at(5,  SIG_RISE, 4'h1, "s6_rise5");
    expect_at(6,  SIG_RISE, 4'h0, "s6_rise6");
    expect_at(24, SIG_REP,  4'h0, "s6_rep24");
    expect_at(25, SIG_REP,  4'h1, "s6_rep25");
    expect_at(26, SIG_REP,  4'h0, "s6_rep26");
    rst = 1'b0;
    run_to(2);
    din[0] = 1'b1;
    run_to(30);

    check("sb_empty", sb.size(), 0);
    check("total_rise_ch0", rise_cnt[0], 4);
    for (int c = 1; c < 4; c++) check($sformatf("total_rise_ch%0d", c), rise_cnt[c], 2);
    for (int c = 0; c < 4; c++) check($sformatf("total_fall_ch%0d", c), fall_cnt[c], 2);
    check("total_rep_ch0", rep_cnt[0], 1);
    check("total_rep_ch1", rep_cnt[1], 0);
    check("total_rep_ch2", rep_cnt[2], 0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
